store_instruction: RTL and testbench
====================================

# store_instruction

Store-side counterpart to the load path. Accepts store instructions (address + data) from the reservation station, holds them in a small in-order store buffer, and drains them to data memory through a registered write handshake. While stores are pending, it supplies store-to-load forwarding data to the load unit, which consumes `forwarded_data`.

## Interface
Parameters:
- `DEPTH`, 4: store buffer entries; power of two, ≥2.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `store_en`  in  1  store request this cycle.
- `store_addr`  in  `ADDR_W`  store address.
- `store_data`  in  `DATA_W`  store data.
- `store_ready`  out  1  buffer can accept a store; combinational, `count < DEPTH`.
- `mem_we`  out  1  memory write request; registered.
- `mem_addr`  out  `ADDR_W`  write address; registered.
- `mem_wdata`  out  `DATA_W`  write data; registered.
- `mem_ack`  in  1  memory accepted the write; sampled only while `mem_we`=1.
- `ld_addr`  in  `ADDR_W`  load address to check for forwarding.
- `fwd_valid`  out  1  a pending store matches `ld_addr`; combinational.
- `forwarded_data`  out  `DATA_W`  data of the youngest matching store, else 0; combinational.
- `sb_empty`  out  1  `count == 0`.

## Operation
- Buffer is a circular FIFO: `head`, `tail` and `count` (range 0..`DEPTH`). Each entry is valid/addr/data.
- Push: on an edge with `store_en && store_ready`, write the entry at `tail` and advance `tail` (wraps at `DEPTH`). If `store_en` is asserted while full, the store is dropped and no state changes; the issuer must honour `store_ready`.
- Drain FSM has two states:
  - IDLE: if `count > 0`, load `mem_addr`/`mem_wdata` from `head`, set `mem_we`=1, go to ISSUE.
  - ISSUE: hold `mem_we`, `mem_addr` and `mem_wdata` stable until `mem_ack`=1. On that edge: pop `head` (clear its valid bit, advance with wrap), set `mem_we`=0, return to IDLE.
- The head entry stays in the buffer, and stays forwardable, until its ack edge.
- Push and pop on the same edge: `count` is unchanged and both pointers advance. If the buffer was full that cycle, `store_ready`=0, so only the pop occurs.
- Forwarding compares `ld_addr` against every valid entry. On multiple hits, the youngest entry (closest to `tail`) wins. A store pushed on the current edge is visible the next cycle; there is no same-cycle bypass of `store_data`.
- Reset (async, any time, including mid-ISSUE): `head`=`tail`=`count`=0, all valid bits cleared, FSM to IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Pending stores are discarded. A `mem_ack` arriving after reset is ignored.

## Timing
- Push at edge N: `mem_we` rises at edge N+1 at the earliest, when the FSM is in IDLE.
- Write occupancy is 1 + (cycles until ack). An ack on the first ISSUE cycle gives one write per 2 cycles; there is always one IDLE bubble between writes.
- `store_ready`, `fwd_valid`, `forwarded_data` and `sb_empty` reflect register state after the last edge. Their only input-driven dependence is `ld_addr`.
- Reset values: `store_ready`=1, `sb_empty`=1, `fwd_valid`=0, `forwarded_data`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Configuration
- `STORE_FWD_EN` defined: forwarding comparators are present and behave as described above.
- `STORE_FWD_EN` undefined: no comparators; `fwd_valid` is tied 0 and `forwarded_data` is tied 0. The load path then always reads memory. The drain side is unchanged.

## Test plan
- Reset, then push (0x0010, 0xBEEF) with `mem_ack` tied 1 → next cycle `mem_we`=1, `mem_addr`=0x0010, `mem_wdata`=0xBEEF; one cycle later `mem_we`=0 and `sb_empty`=1.
- Hold `mem_ack`=0 and push 4 stores → `store_ready`=0. A 5th push (0x0050, 0x5555) is dropped. Release ack → exactly 4 writes, in order, each separated by one idle cycle.
- Push (0x0020, 0x1111), then (0x0020, 0x2222), with ack held low; `ld_addr`=0x0020 → `fwd_valid`=1, `forwarded_data`=0x2222. With `ld_addr`=0x0030 → `fwd_valid`=0, `forwarded_data`=0.
- Full buffer, ack on the head while `store_en`=1 → no push that cycle and `count` drops to 3. Next-cycle push is accepted; the `tail` wrap is verified by write order.
- Assert `reset`=0 mid-ISSUE with 3 entries pending → `mem_we`=0 immediately, `sb_empty`=1; no writes occur after release.
- Build without `STORE_FWD_EN`, repeat the forwarding scenario → `fwd_valid`=0, `forwarded_data`=0; drain order and values are unchanged.

Source files
------------

// File: rtl/store_instruction.sv
// In-order store buffer with a registered two-state write drain and store-to-load forwarding.
// Optional macro STORE_FWD_EN enables the forwarding comparators; without it fwd_valid/forwarded_data are tied 0.
module store_instruction #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              store_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] forwarded_data,
    output logic              sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              push, pop;

    assign store_ready = (count_q < CNT_W'(DEPTH));
    assign sb_empty    = (count_q == '0);
    assign push        = store_en && store_ready;
    // Pop happens on the ack edge; until then the head stays valid and forwardable.
    assign pop         = (state_q == ISSUE) && mem_ack;

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = store_addr;
            data_d[tail_q]  = store_data;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                    mem_we_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Payload storage needs no reset: entries are only read while their valid bit is set.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

`ifdef STORE_FWD_EN
    always_comb begin : fwd_scan
        logic [PTR_W-1:0] idx;
        fwd_valid      = 1'b0;
        forwarded_data = '0;
        idx            = '0;
        // Scan oldest to youngest so the last hit is the youngest matching store.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
                fwd_valid      = 1'b1;
                forwarded_data = data_q[idx];
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign fwd_valid      = 1'b0;
    assign forwarded_data = '0;
`endif

endmodule

// File: tb/tb_store_instruction.sv
// Randomized and directed bench for store_instruction against a queue-based model of the store buffer.
module tb_store_instruction;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        store_en = 1'b0;
    logic [15:0] store_addr = '0;
    logic [15:0] store_data = '0;
    logic        store_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] ld_addr = '0;
    logic        fwd_valid;
    logic [15:0] forwarded_data;
    logic        sb_empty;

    store_instruction #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .store_en(store_en), .store_addr(store_addr), .store_data(store_data),
        .store_ready(store_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .fwd_valid(fwd_valid), .forwarded_data(forwarded_data),
        .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } st_t;

    st_t  q[$];          // accepted stores not yet acknowledged, oldest first
    logic exp_we = 1'b0; // a write request is expected to be outstanding
    int   checks = 0;
    int   failures = 0;
    int   writes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void exp_fwd(input logic [15:0] ld, output logic v, output logic [15:0] d);
        v = 1'b0;
        d = '0;
`ifdef STORE_FWD_EN
        foreach (q[i]) begin
            if (q[i].addr == ld) begin
                v = 1'b1;
                d = q[i].data;
            end
        end
`endif
    endfunction

    task automatic check_outputs();
        logic        v;
        logic [15:0] d;
        exp_fwd(ld_addr, v, d);
        check("store_ready", 32'(store_ready), 32'(q.size() < DEPTH));
        check("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        check("fwd_valid", 32'(fwd_valid), 32'(v));
        check("forwarded_data", 32'(forwarded_data), 32'(d));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we && q.size() > 0) begin
            check("mem_addr", 32'(mem_addr), 32'(q[0].addr));
            check("mem_wdata", 32'(mem_wdata), 32'(q[0].data));
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model on the rising edge.
    task automatic cyc(input logic en, input logic [15:0] a, input logic [15:0] d,
                       input logic ack, input logic [15:0] ld);
        int  n;
        logic do_push, do_pop;
        store_en   = en;
        store_addr = a;
        store_data = d;
        mem_ack    = ack;
        ld_addr    = ld;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        n       = q.size();
        do_push = en && (n < DEPTH);
        do_pop  = exp_we && ack;
        if (do_pop) begin
            $display("write addr=%h data=%h", q[0].addr, q[0].data);
            writes++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{addr: a, data: d});
        exp_we = exp_we ? !ack : (n > 0);
        #1;
    endtask

    task automatic do_reset();
        store_en = 1'b0;
        mem_ack  = 1'b0;
        reset    = 1'b0;
        #2;
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst sb_empty", 32'(sb_empty), 32'd1);
        check("rst store_ready", 32'(store_ready), 32'd1);
        check("rst fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst forwarded_data", 32'(forwarded_data), 32'd0);
        q.delete();
        exp_we = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        do_reset();

        // Single store drained with ack tied high.
        cyc(1, 16'h0010, 16'hBEEF, 1, 16'h0010);
        repeat (3) cyc(0, 0, 0, 1, 16'h0010);

        // Fill with ack held low; fifth push must be dropped.
        for (int i = 0; i < 4; i++) cyc(1, 16'h0010 + 16'(i * 16), 16'h1000 + 16'(i), 0, 16'h0020);
        cyc(1, 16'h0050, 16'h5555, 0, 16'h0050);
        repeat (2) cyc(0, 0, 0, 0, 16'h0030);
        w0 = writes;
        repeat (10) cyc(0, 0, 0, 1, 16'h0040);
        check("four writes", 32'(writes - w0), 32'd4);

        // Forwarding: youngest of two same-address stores wins.
        do_reset();
        cyc(1, 16'h0020, 16'h1111, 0, 16'h0020);
        cyc(1, 16'h0020, 16'h2222, 0, 16'h0020);
        cyc(0, 0, 0, 0, 16'h0020);
        cyc(0, 0, 0, 0, 16'h0030);
        repeat (6) cyc(0, 0, 0, 1, 16'h0020);

        // Full buffer, ack on head while store_en is high, then a push that wraps tail.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 0, 16'h0100);
        cyc(0, 0, 0, 0, 16'h0102);
        cyc(1, 16'h0777, 16'h7777, 1, 16'h0777);
        cyc(1, 16'h0104, 16'hA004, 0, 16'h0104);
        repeat (12) cyc(0, 0, 0, 1, 16'h0104);

        // Reset during an outstanding write discards everything; later acks are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 16'h0200 + 16'(i), 16'hB000 + 16'(i), 0, 16'h0200);
        cyc(0, 0, 0, 0, 16'h0200);
        check("pre-reset mem_we", 32'(mem_we), 32'd1);
        w0 = writes;
        do_reset();
        repeat (5) cyc(0, 0, 0, 1, 16'h0200);
        check("no writes after reset", 32'(writes - w0), 32'd0);

        // Random traffic over a small address set so forwarding hits and multi-hits are common.
        for (int n = 0; n < 2000; n++) begin
            cyc(1'($urandom_range(0, 1)),
                16'h0020 + 16'($urandom_range(0, 3) * 4),
                16'($urandom),
                1'($urandom_range(0, 2) != 0),
                16'h0020 + 16'($urandom_range(0, 4) * 4));
        end
        repeat (20) cyc(0, 0, 0, 1, 16'h0020);
        check("final empty", 32'(sb_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
